// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: FSM states, legal read-latency limits and byte-parity helper for sram_ctrl_be
package sram_ctrl_pkg;

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic logic byte_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sram_ctrl_be_if.sv
// sram_ctrl_be_if: request/response bus between a requester (master) and sram_ctrl_be (slave)
interface sram_ctrl_be_if #(
    parameter int WIDTH     = 32,
    parameter int ADDR_SIZE = 8,
    parameter int BE_WIDTH  = WIDTH / 8
);
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic                 req_wr_i;
    logic [ADDR_SIZE-1:0] req_addr_i;
    logic [WIDTH-1:0]     req_wdata_i;
    logic [BE_WIDTH-1:0]  req_be_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [WIDTH-1:0]     rsp_rdata_o;
    logic                 rsp_err_o;

    modport master (
        output req_valid_i, req_wr_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_wr_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/sram_ctrl_be_rsp_fifo.sv
// sram_rsp_fifo: small in-order response queue; head is zero whenever the queue is empty
module sram_rsp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid_o = count != '0;
    assign pop     = pop_i & valid_o;
    assign data_o  = valid_o ? mem[rd_ptr] : '0;

    // payload storage; the controller never pushes into a full queue
    always_ff @(posedge clk_i) begin
        if (push_i) mem[wr_ptr] <= push_data_i;
    end

    // circular pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_i) wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(push_i) - CW'(pop);
        end
    end
endmodule

// File: rtl/sram_ctrl_be.sv
// sram_ctrl_be: single-port SRAM controller with byte enables, clear-on-reset and in-order responses.
// Per-byte even parity with write-side fault injection is compiled in with SRAM_PARITY_EN.
module sram_ctrl_be
    import sram_ctrl_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_SIZE  = $clog2(DEPTH),
    parameter int BE_WIDTH   = WIDTH / 8,
    parameter int RD_LATENCY = RD_LAT_MIN
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    sram_ctrl_be_if.slave bus,
`ifdef SRAM_PARITY_EN
    input  logic          par_inject_i,
`endif
    output logic          init_done_o
);
    localparam logic [31:0] DEPTH_U = DEPTH;
    localparam int          RW      = WIDTH + 1;
    localparam bit          PIPE    = RD_LATENCY == RD_LAT_MAX;

    state_e               state, state_nxt;
    logic [ADDR_SIZE-1:0] cnt, idx, w_addr;
    logic [1:0]           outstanding;
    logic                 acc, pop, in_range, we, par_err, pipe_valid, rsp_valid;
    logic [WIDTH-1:0]     mem [DEPTH];
    logic [WIDTH-1:0]     rword, w_data;
    logic [BE_WIDTH-1:0]  w_be;
    logic [RW-1:0]        rsp, pipe_data, head;

    assign acc      = bus.req_valid_i & bus.req_ready_o;
    assign pop      = rsp_valid & bus.rsp_ready_i;
    assign in_range = 32'(bus.req_addr_i) < DEPTH_U;
    assign idx      = in_range ? bus.req_addr_i : '0;
    assign rword    = mem[idx];

    // single write port shared by the clear walk and request writes
    assign we     = (state == ST_INIT) | (acc & bus.req_wr_i & in_range);
    assign w_addr = (state == ST_INIT) ? cnt : bus.req_addr_i;
    assign w_data = (state == ST_INIT) ? '0 : bus.req_wdata_i;
    assign w_be   = (state == ST_INIT) ? '1 : bus.req_be_i;

    // byte-enabled storage update
    always_ff @(posedge clk_i) begin
        if (we) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (w_be[i]) mem[w_addr][i*8 +: 8] <= w_data[i*8 +: 8];
            end
        end
    end

`ifdef SRAM_PARITY_EN
    logic [BE_WIDTH-1:0] par [DEPTH];
    logic                w_inj;

    assign w_inj = (state == ST_RUN) & par_inject_i;

    // one even-parity bit per byte, optionally inverted to plant a fault
    always_ff @(posedge clk_i) begin
        if (we) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (w_be[i]) par[w_addr][i] <= byte_par(w_data[i*8 +: 8]) ^ w_inj;
            end
        end
    end

    // any byte whose stored parity disagrees with its data flags the read
    always_comb begin
        par_err = 1'b0;
        for (int i = 0; i < BE_WIDTH; i++) begin
            par_err = par_err | (par[idx][i] ^ byte_par(rword[i*8 +: 8]));
        end
    end
`else
    assign par_err = 1'b0;
`endif

    // writes answer with zero data; out-of-range answers zero data with the error bit
    assign rsp = {~in_range | (~bus.req_wr_i & par_err), rword & {WIDTH{~bus.req_wr_i & in_range}}};

    // extra response stage used only for the two-cycle latency build
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_valid <= 1'b0;
            pipe_data  <= '0;
        end else begin
            pipe_valid <= acc;
            pipe_data  <= rsp;
        end
    end

    sram_rsp_fifo #(.WIDTH(RW), .DEPTH(RD_LATENCY + 1)) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (PIPE ? pipe_valid : acc),
        .push_data_i (PIPE ? pipe_data : rsp),
        .pop_i       (bus.rsp_ready_i),
        .valid_o     (rsp_valid),
        .data_o      (head)
    );

    assign bus.rsp_valid_o = rsp_valid;
    assign {bus.rsp_err_o, bus.rsp_rdata_o} = head;

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= ST_INIT;
        else state <= state_nxt;
    end

    // leave INIT once the last word has been cleared
    always_comb begin
        state_nxt = (state == ST_INIT && cnt == ADDR_SIZE'(DEPTH - 1)) ? ST_RUN : state;
    end

    // accept only while the response queue is guaranteed room
    always_comb begin
        bus.req_ready_o = (state == ST_RUN) && (outstanding < 2'(RD_LATENCY + 1));
        init_done_o     = state == ST_RUN;
    end

    // clear pointer walks the array once; outstanding counts accepted but unpopped requests
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt         <= '0;
            outstanding <= '0;
        end else begin
            if (state == ST_INIT && state_nxt == ST_INIT) cnt <= cnt + 1'b1;
            outstanding <= outstanding + 2'(acc) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_sram_ctrl_be.sv
// tb_sram_ctrl_be: directed bench; instance A is DEPTH=256/latency 1, instance B is DEPTH=200/latency 2
module tb_sram_ctrl_be;
    logic clk_i = 1'b0;
    logic rst_a_n, rst_b_n;
    logic done_a, done_b;
    int   checks = 0;
    int   errors = 0;
`ifdef SRAM_PARITY_EN
    logic par_inj = 1'b0;
`endif

    sram_ctrl_be_if #(.WIDTH(32), .ADDR_SIZE(8)) ifa ();
    sram_ctrl_be_if #(.WIDTH(32), .ADDR_SIZE(8)) ifb ();

    sram_ctrl_be #(.WIDTH(32), .DEPTH(256), .RD_LATENCY(1)) dut_a (
        .clk_i       (clk_i),
        .rst_ni      (rst_a_n),
        .bus         (ifa),
`ifdef SRAM_PARITY_EN
        .par_inject_i(par_inj),
`endif
        .init_done_o (done_a)
    );

    sram_ctrl_be #(.WIDTH(32), .DEPTH(200), .RD_LATENCY(2)) dut_b (
        .clk_i       (clk_i),
        .rst_ni      (rst_b_n),
        .bus         (ifb),
`ifdef SRAM_PARITY_EN
        .par_inject_i(par_inj),
`endif
        .init_done_o (done_b)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] pat(input int i);
        return 32'hA500_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    // one request on instance A (b=0) or B (b=1); returns the matching response
    task automatic op(input bit b, input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, output logic [31:0] rd, output logic er);
        int n;
        if (b) begin
            ifb.req_valid_i = 1'b1; ifb.req_wr_i = wr; ifb.req_addr_i = addr;
            ifb.req_wdata_i = wd; ifb.req_be_i = be;
        end else begin
            ifa.req_valid_i = 1'b1; ifa.req_wr_i = wr; ifa.req_addr_i = addr;
            ifa.req_wdata_i = wd; ifa.req_be_i = be;
        end
        n = 0;
        while (!(b ? ifb.req_ready_o : ifa.req_ready_o) && n < 400) begin
            @(posedge clk_i); #1; n++;
        end
        @(posedge clk_i); #1;
        if (b) ifb.req_valid_i = 1'b0; else ifa.req_valid_i = 1'b0;
        while (!(b ? ifb.rsp_valid_o : ifa.rsp_valid_o) && n < 400) begin
            @(posedge clk_i); #1; n++;
        end
        rd = b ? ifb.rsp_rdata_o : ifa.rsp_rdata_o;
        er = b ? ifb.rsp_err_o : ifa.rsp_err_o;
        if (n >= 400) begin
            checks++; errors++;
            $display("FAIL op_timeout inst=%0d addr=%h: waited %0d cycles, limit 400", b, addr, n);
        end
    endtask

    task automatic test_reset;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks += 6;
        if (ifa.req_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ifa.req_ready_o); end
        if (ifa.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", ifa.rsp_valid_o); end
        if (ifa.rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", ifa.rsp_rdata_o); end
        if (ifa.rsp_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", ifa.rsp_err_o); end
        if (done_a !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b want 0", done_a); end
        if (ifb.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_b_rsp_valid got %b want 0", ifb.rsp_valid_o); end
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            @(posedge clk_i); #1;
            checks += 3;
            if (ifa.req_ready_o !== (k >= 256)) begin
                errors++; $display("FAIL init_a_ready cycle %0d got %b want %b", k, ifa.req_ready_o, k >= 256);
            end
            if (done_a !== (k >= 256)) begin
                errors++; $display("FAIL init_a_done cycle %0d got %b want %b", k, done_a, k >= 256);
            end
            if (done_b !== (k >= 200)) begin
                errors++; $display("FAIL init_b_done cycle %0d got %b want %b", k, done_b, k >= 200);
            end
        end
    endtask

    task automatic test_init_read;
        logic [31:0] rd;
        logic        er;
        ifa.rsp_ready_i = 1'b1; ifb.rsp_ready_i = 1'b1;
        op(1'b0, 1'b0, 8'h7F, 32'h0, 4'h0, rd, er);
        checks += 2;
        if (rd !== 32'h0) begin errors++; $display("FAIL init_read_data got %h want 00000000", rd); end
        if (er !== 1'b0) begin errors++; $display("FAIL init_read_err got %b want 0", er); end
    endtask

    task automatic test_byte_enable;
        logic [31:0] rd;
        logic        er;
        op(1'b0, 1'b1, 8'd5, 32'hAABBCCDD, 4'b1111, rd, er);
        checks += 2;
        if (rd !== 32'h0) begin errors++; $display("FAIL wr_rsp_data got %h want 00000000", rd); end
        if (er !== 1'b0) begin errors++; $display("FAIL wr_rsp_err got %b want 0", er); end
        op(1'b0, 1'b1, 8'd5, 32'h11223344, 4'b0101, rd, er);
        op(1'b0, 1'b0, 8'd5, 32'h0, 4'h0, rd, er);
        checks += 2;
        if (rd !== 32'hAA22CC44) begin errors++; $display("FAIL be_merge got %h want AA22CC44", rd); end
        if (er !== 1'b0) begin errors++; $display("FAIL be_merge_err got %b want 0", er); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        logic        er;
        for (int i = 0; i < 8; i++) op(1'b1, 1'b1, 8'(i), pat(i), 4'hF, rd, er);
        @(posedge clk_i); #1;
        ifb.req_wr_i = 1'b0; ifb.req_valid_i = 1'b1; ifb.req_addr_i = 8'd0;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                checks++;
                if (ifb.req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready k=%0d got %b want 1", k, ifb.req_ready_o); end
            end
            @(posedge clk_i); #1;
            checks++;
            if (ifb.rsp_valid_o !== (k >= 1 && k <= 8)) begin
                errors++; $display("FAIL b2b_valid k=%0d got %b want %b", k, ifb.rsp_valid_o, k >= 1 && k <= 8);
            end
            if (k >= 1 && k <= 8) begin
                checks++;
                if (ifb.rsp_rdata_o !== pat(k - 1)) begin
                    errors++; $display("FAIL b2b_data k=%0d got %h want %h", k, ifb.rsp_rdata_o, pat(k - 1));
                end
            end
            ifb.req_valid_i = k < 7;
            ifb.req_addr_i  = 8'(k + 1);
        end
    endtask

    task automatic test_backpressure;
        ifb.rsp_ready_i = 1'b0; ifb.req_wr_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ifb.req_valid_i = 1'b1; ifb.req_addr_i = 8'(k);
            checks++;
            if (ifb.req_ready_o !== 1'b1) begin errors++; $display("FAIL bp_accept k=%0d got %b want 1", k, ifb.req_ready_o); end
            @(posedge clk_i); #1;
        end
        ifb.req_addr_i = 8'd3;
        for (int k = 0; k < 4; k++) begin
            checks += 3;
            if (ifb.req_ready_o !== 1'b0) begin errors++; $display("FAIL bp_full_ready k=%0d got %b want 0", k, ifb.req_ready_o); end
            if (ifb.rsp_valid_o !== 1'b1) begin errors++; $display("FAIL bp_hold_valid k=%0d got %b want 1", k, ifb.rsp_valid_o); end
            if (ifb.rsp_rdata_o !== pat(0)) begin errors++; $display("FAIL bp_hold_data k=%0d got %h want %h", k, ifb.rsp_rdata_o, pat(0)); end
            @(posedge clk_i); #1;
        end
        checks += 3;
        if (ifb.req_ready_o !== 1'b0) begin errors++; $display("FAIL bp_full_ready_end got %b want 0", ifb.req_ready_o); end
        if (ifb.rsp_valid_o !== 1'b1) begin errors++; $display("FAIL bp_hold_valid_end got %b want 1", ifb.rsp_valid_o); end
        if (ifb.rsp_rdata_o !== pat(0)) begin errors++; $display("FAIL bp_hold_data_end got %h want %h", ifb.rsp_rdata_o, pat(0)); end
        ifb.rsp_ready_i = 1'b1; ifb.req_valid_i = 1'b0;
        for (int k = 1; k < 3; k++) begin
            @(posedge clk_i); #1;
            checks += 3;
            if (ifb.rsp_valid_o !== 1'b1) begin errors++; $display("FAIL bp_drain_valid k=%0d got %b want 1", k, ifb.rsp_valid_o); end
            if (ifb.rsp_rdata_o !== pat(k)) begin errors++; $display("FAIL bp_drain_data k=%0d got %h want %h", k, ifb.rsp_rdata_o, pat(k)); end
            if (ifb.req_ready_o !== 1'b1) begin errors++; $display("FAIL bp_drain_ready k=%0d got %b want 1", k, ifb.req_ready_o); end
        end
        @(posedge clk_i); #1;
        checks++;
        if (ifb.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", ifb.rsp_valid_o); end
    endtask

    task automatic test_out_of_range;
        logic [31:0] rd;
        logic        er;
        logic [7:0]  probe [3];
        logic [31:0] want [3];
        op(1'b1, 1'b0, 8'd210, 32'h0, 4'h0, rd, er);
        checks += 2;
        if (rd !== 32'h0) begin errors++; $display("FAIL oor_read_data got %h want 00000000", rd); end
        if (er !== 1'b1) begin errors++; $display("FAIL oor_read_err got %b want 1", er); end
        op(1'b1, 1'b1, 8'd210, 32'hFFFFFFFF, 4'hF, rd, er);
        checks += 2;
        if (rd !== 32'h0) begin errors++; $display("FAIL oor_write_data got %h want 00000000", rd); end
        if (er !== 1'b1) begin errors++; $display("FAIL oor_write_err got %b want 1", er); end
        probe[0] = 8'd0;   want[0] = pat(0);
        probe[1] = 8'd10;  want[1] = 32'h0;
        probe[2] = 8'd199; want[2] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            op(1'b1, 1'b0, probe[i], 32'h0, 4'h0, rd, er);
            checks += 2;
            if (rd !== want[i]) begin errors++; $display("FAIL oor_untouched addr=%0d got %h want %h", probe[i], rd, want[i]); end
            if (er !== 1'b0) begin errors++; $display("FAIL oor_untouched_err addr=%0d got %b want 0", probe[i], er); end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        logic        er;
        int          n;
        @(posedge clk_i); #1;
        ifb.rsp_ready_i = 1'b0; ifb.req_valid_i = 1'b1; ifb.req_wr_i = 1'b0; ifb.req_addr_i = 8'd5;
        repeat (2) @(posedge clk_i);
        #1;
        ifb.req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        checks += 2;
        if (ifb.rsp_valid_o !== 1'b1) begin errors++; $display("FAIL mid_queued got %b want 1", ifb.rsp_valid_o); end
        if (ifb.rsp_rdata_o !== pat(5)) begin errors++; $display("FAIL mid_queued_data got %h want %h", ifb.rsp_rdata_o, pat(5)); end
        #2 rst_b_n = 1'b0;
        #1;
        checks += 5;
        if (ifb.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", ifb.rsp_valid_o); end
        if (ifb.req_ready_o !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b want 0", ifb.req_ready_o); end
        if (done_b !== 1'b0) begin errors++; $display("FAIL mid_rst_done got %b want 0", done_b); end
        if (ifb.rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL mid_rst_rdata got %h want 0", ifb.rsp_rdata_o); end
        if (ifb.rsp_err_o !== 1'b0) begin errors++; $display("FAIL mid_rst_err got %b want 0", ifb.rsp_err_o); end
        @(posedge clk_i); #1;
        rst_b_n = 1'b1; ifb.rsp_ready_i = 1'b1;
        n = 0;
        while (!done_b && n < 300) begin @(posedge clk_i); #1; n++; end
        checks += 2;
        if (n !== 200) begin errors++; $display("FAIL mid_init_len got %0d cycles want 200", n); end
        if (ifb.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL mid_discard got %b want 0", ifb.rsp_valid_o); end
        op(1'b1, 1'b0, 8'd5, 32'h0, 4'h0, rd, er);
        checks += 2;
        if (rd !== 32'h0) begin errors++; $display("FAIL mid_cleared got %h want 00000000", rd); end
        if (er !== 1'b0) begin errors++; $display("FAIL mid_cleared_err got %b want 0", er); end
    endtask

`ifdef SRAM_PARITY_EN
    task automatic test_parity;
        logic [31:0] rd;
        logic        er;
        par_inj = 1'b1;
        op(1'b0, 1'b1, 8'd9, 32'h12345678, 4'hF, rd, er);
        par_inj = 1'b0;
        op(1'b0, 1'b0, 8'd9, 32'h0, 4'h0, rd, er);
        checks += 2;
        if (rd !== 32'h12345678) begin errors++; $display("FAIL par_inj_data got %h want 12345678", rd); end
        if (er !== 1'b1) begin errors++; $display("FAIL par_inj_err got %b want 1", er); end
        op(1'b0, 1'b1, 8'd9, 32'h12345678, 4'hF, rd, er);
        op(1'b0, 1'b0, 8'd9, 32'h0, 4'h0, rd, er);
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL par_clean_err got %b want 0", er); end
    endtask
`endif

    initial begin
        ifa.req_valid_i = 1'b0; ifa.req_wr_i = 1'b0; ifa.req_addr_i = '0;
        ifa.req_wdata_i = '0; ifa.req_be_i = '0; ifa.rsp_ready_i = 1'b1;
        ifb.req_valid_i = 1'b0; ifb.req_wr_i = 1'b0; ifb.req_addr_i = '0;
        ifb.req_wdata_i = '0; ifb.req_be_i = '0; ifb.rsp_ready_i = 1'b1;
        test_reset;
        test_init_read;
        test_byte_enable;
        test_back_to_back;
        test_backpressure;
        test_out_of_range;
        test_reset_mid;
`ifdef SRAM_PARITY_EN
        test_parity;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
